// File: rtl/vrs_pkg.sv
// vrs_pkg: shared shading-rate codes, walker state type and rate decode for the VRS blocks.
//   SR_1X1..SR_2X2 : rate codes (0=1x1, 1=2 wide, 2=2 tall, 3=2x2)
//   srate_to_step  : rate code -> {wide, tall}
package vrs_pkg;
    localparam int SRATE_WIDTH = 2;
    localparam logic [SRATE_WIDTH-1:0] SR_1X1 = 2'd0;
    localparam logic [SRATE_WIDTH-1:0] SR_2X1 = 2'd1;
    localparam logic [SRATE_WIDTH-1:0] SR_1X2 = 2'd2;
    localparam logic [SRATE_WIDTH-1:0] SR_2X2 = 2'd3;
    typedef enum logic {ST_IDLE, ST_WALK} walk_state_t;
    function automatic logic [1:0] srate_to_step(input logic [SRATE_WIDTH-1:0] code);
        return {code == SR_2X1 || code == SR_2X2, code == SR_1X2 || code == SR_2X2};
    endfunction
endpackage

// File: rtl/vrs_sat_counter.sv
// vrs_sat_counter: saturating event counter with synchronous clear.
//   clk, rst_n : clock, async active-low reset
//   inc        : count one event
//   clr        : synchronous clear, wins over inc
//   cnt        : count, sticks at all-ones
module vrs_sat_counter #(
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic                  clr,
    output logic [STAT_WIDTH-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/vrs_coarse_walker.sv
// vrs_coarse_walker: walks each accepted tile in coarse-pixel blocks and emits one invocation per block.
//   tile_in_*  : tile request (addr, rate code) with valid/ready
//   frag_out_* : registered invocation (tile, origin x/y, wide, tall, last) with valid/ready
//   stats_clr  : clears statistics; stat_tiles / stat_frags are saturating counts
module vrs_coarse_walker #(
    parameter int TILE_ADDR_BITS = 13,
    parameter int SRATE_WIDTH    = vrs_pkg::SRATE_WIDTH,
    parameter int TILE_W_LOG2    = 3,
    parameter int TILE_H_LOG2    = 3,
    parameter int STAT_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tile_in_valid,
    output logic                      tile_in_ready,
    input  logic [TILE_ADDR_BITS-1:0] tile_in_addr,
    input  logic [SRATE_WIDTH-1:0]    tile_in_srate,
    output logic                      frag_out_valid,
    input  logic                      frag_out_ready,
    output logic [TILE_ADDR_BITS-1:0] frag_out_tile_addr,
    output logic [TILE_W_LOG2-1:0]    frag_out_x,
    output logic [TILE_H_LOG2-1:0]    frag_out_y,
    output logic                      frag_out_wide,
    output logic                      frag_out_tall,
    output logic                      frag_out_last,
    input  logic                      stats_clr,
    output logic [STAT_WIDTH-1:0]     stat_tiles,
    output logic [STAT_WIDTH-1:0]     stat_frags
);
    import vrs_pkg::*;

    walk_state_t             r_state;
    logic [1:0]              w_step;
    logic                    w_hs;
    logic                    w_accept;
    logic [TILE_W_LOG2-1:0]  w_nx;
    logic [TILE_H_LOG2-1:0]  w_ny;

    // Coordinates live in tile-width registers, so x+step wrapping to 0 marks the end of a row
    // (and y+step wrapping marks the final row).
    function automatic logic is_last(input logic [TILE_W_LOG2-1:0] x, input logic [TILE_H_LOG2-1:0] y,
                                     input logic wide, input logic tall);
        return (x + TILE_W_LOG2'(wide ? 2 : 1)) == '0 && (y + TILE_H_LOG2'(tall ? 2 : 1)) == '0;
    endfunction

    assign w_hs          = frag_out_valid && frag_out_ready;
    assign tile_in_ready = r_state == ST_IDLE || (w_hs && frag_out_last);
    assign w_accept      = tile_in_valid && tile_in_ready;
    assign w_step        = srate_to_step(tile_in_srate);
    assign w_nx          = frag_out_x + TILE_W_LOG2'(frag_out_wide ? 2 : 1);
    assign w_ny          = w_nx == '0 ? frag_out_y + TILE_H_LOG2'(frag_out_tall ? 2 : 1) : frag_out_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state            <= ST_IDLE;
            frag_out_valid     <= 1'b0;
            frag_out_tile_addr <= '0;
            frag_out_x         <= '0;
            frag_out_y         <= '0;
            frag_out_wide      <= 1'b0;
            frag_out_tall      <= 1'b0;
            frag_out_last      <= 1'b0;
        end else if (w_accept) begin
            r_state            <= ST_WALK;
            frag_out_valid     <= 1'b1;
            frag_out_tile_addr <= tile_in_addr;
            frag_out_x         <= '0;
            frag_out_y         <= '0;
            frag_out_wide      <= w_step[1];
            frag_out_tall      <= w_step[0];
            frag_out_last      <= is_last('0, '0, w_step[1], w_step[0]);
        end else if (w_hs && frag_out_last) begin
            r_state            <= ST_IDLE;
            frag_out_valid     <= 1'b0;
            frag_out_last      <= 1'b0;
        end else if (w_hs) begin
            frag_out_x         <= w_nx;
            frag_out_y         <= w_ny;
            frag_out_last      <= is_last(w_nx, w_ny, frag_out_wide, frag_out_tall);
        end
    end

    vrs_sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_frags (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_hs),
        .clr   (stats_clr),
        .cnt   (stat_frags)
    );

    vrs_sat_counter #(.STAT_WIDTH(STAT_WIDTH)) u_tiles (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_hs && frag_out_last),
        .clr   (stats_clr),
        .cnt   (stat_tiles)
    );
endmodule

// File: tb/tb_vrs_coarse_walker.sv
// tb_vrs_coarse_walker: directed + randomized bench for vrs_coarse_walker against a tile-walk reference model.
module tb_vrs_coarse_walker;
    localparam int TW = 8;
    localparam int TH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tile_in_valid = 1'b0;
    logic        tile_in_ready;
    logic [12:0] tile_in_addr = '0;
    logic [1:0]  tile_in_srate = '0;
    logic        frag_out_valid;
    logic        frag_out_ready = 1'b0;
    logic [12:0] frag_out_tile_addr;
    logic [2:0]  frag_out_x;
    logic [2:0]  frag_out_y;
    logic        frag_out_wide;
    logic        frag_out_tall;
    logic        frag_out_last;
    logic        stats_clr = 1'b0;
    logic [31:0] stat_tiles;
    logic [31:0] stat_frags;

    logic        s_tv = 1'b0;
    logic        s_tr;
    logic [1:0]  s_sr = '0;
    logic        s_fv;
    logic        s_fr = 1'b0;
    logic [12:0] s_addr;
    logic [2:0]  s_x;
    logic [2:0]  s_y;
    logic        s_wide;
    logic        s_tall;
    logic        s_last;
    logic        s_clr = 1'b0;
    logic [3:0]  s_tiles;
    logic [3:0]  s_frags;

    int checks = 0;
    int errors = 0;
    int qx[$];
    int qy[$];
    bit ql[$];
    bit ew;
    bit et;

    always #5 clk = ~clk;

    vrs_coarse_walker dut (
        .clk(clk), .rst_n(rst_n),
        .tile_in_valid(tile_in_valid), .tile_in_ready(tile_in_ready),
        .tile_in_addr(tile_in_addr), .tile_in_srate(tile_in_srate),
        .frag_out_valid(frag_out_valid), .frag_out_ready(frag_out_ready),
        .frag_out_tile_addr(frag_out_tile_addr), .frag_out_x(frag_out_x), .frag_out_y(frag_out_y),
        .frag_out_wide(frag_out_wide), .frag_out_tall(frag_out_tall), .frag_out_last(frag_out_last),
        .stats_clr(stats_clr), .stat_tiles(stat_tiles), .stat_frags(stat_frags)
    );

    vrs_coarse_walker #(.STAT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .tile_in_valid(s_tv), .tile_in_ready(s_tr),
        .tile_in_addr(13'h0aa), .tile_in_srate(s_sr),
        .frag_out_valid(s_fv), .frag_out_ready(s_fr),
        .frag_out_tile_addr(s_addr), .frag_out_x(s_x), .frag_out_y(s_y),
        .frag_out_wide(s_wide), .frag_out_tall(s_tall), .frag_out_last(s_last),
        .stats_clr(s_clr), .stat_tiles(s_tiles), .stat_frags(s_frags)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: list every block of an 8x8 tile in row-major order for the given rate code.
    function automatic void build(input logic [1:0] sr);
        int sx;
        int sy;
        ew = (sr == 2'd1 || sr == 2'd3);
        et = (sr == 2'd2 || sr == 2'd3);
        sx = ew ? 2 : 1;
        sy = et ? 2 : 1;
        qx.delete();
        qy.delete();
        ql.delete();
        for (int y = 0; y < TH; y += sy)
            for (int x = 0; x < TW; x += sx) begin
                qx.push_back(x);
                qy.push_back(y);
                ql.push_back(x + sx == TW && y + sy == TH);
            end
    endfunction

    task automatic start(input logic [12:0] addr, input logic [1:0] sr);
        tile_in_valid  = 1'b1;
        tile_in_addr   = addr;
        tile_in_srate  = sr;
        frag_out_ready = 1'b0;
        #1 chk("accept_ready", tile_in_ready, 1);
        @(negedge clk);
    endtask

    task automatic walk(input logic [12:0] addr, input logic [1:0] sr, input bit rnd, input bit stall,
                        input bit chain, input logic [12:0] naddr, input logic [1:0] nsr);
        int n;
        int idx = 0;
        int cyc = 0;
        int held = 0;
        bit rdy;
        build(sr);
        n = qx.size();
        while (idx < n && cyc < 2000) begin
            tile_in_valid = 1'b0;
            tile_in_addr  = 13'($urandom);
            tile_in_srate = 2'($urandom);
            chk("valid", frag_out_valid, 1);
            chk("x", frag_out_x, 64'(qx[idx]));
            chk("y", frag_out_y, 64'(qy[idx]));
            chk("last", frag_out_last, ql[idx]);
            chk("wide", frag_out_wide, ew);
            chk("tall", frag_out_tall, et);
            chk("tile_addr", frag_out_tile_addr, addr);
            rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stall && qx[idx] == 4 && qy[idx] == 2 && held < 5) begin
                rdy = 1'b0;
                held++;
            end
            frag_out_ready = rdy;
            if (rdy && idx == n - 1 && chain) begin
                tile_in_valid = 1'b1;
                tile_in_addr  = naddr;
                tile_in_srate = nsr;
            end
            #1 chk("walk_ready", tile_in_ready, rdy && idx == n - 1);
            @(negedge clk);
            cyc++;
            if (rdy) idx++;
        end
        if (idx < n) chk("walk_timeout", idx, n);
        if (stall) chk("stall_cycles", held, 5);
        frag_out_ready = 1'b0;
    endtask

    task automatic idle_chk();
        tile_in_valid = 1'b0;
        chk("idle_valid", frag_out_valid, 0);
        #1 chk("idle_ready", tile_in_ready, 1);
    endtask

    initial begin
        logic [12:0] ra;
        logic [1:0]  rs;
        int cyc;
        repeat (2) @(negedge clk);
        chk("rst_valid", frag_out_valid, 0);
        chk("rst_ready", tile_in_ready, 1);
        chk("rst_x", frag_out_x, 0);
        chk("rst_y", frag_out_y, 0);
        chk("rst_last", frag_out_last, 0);
        chk("rst_wide", frag_out_wide, 0);
        chk("rst_tall", frag_out_tall, 0);
        chk("rst_addr", frag_out_tile_addr, 0);
        chk("rst_frags", stat_frags, 0);
        chk("rst_tiles", stat_tiles, 0);
        rst_n = 1'b1;
        @(negedge clk);

        start(13'h005, 2'd3);
        walk(13'h005, 2'd3, 0, 0, 0, '0, '0);
        idle_chk();
        chk("frags_2x2", stat_frags, 16);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("clr_frags", stat_frags, 0);
        chk("clr_tiles", stat_tiles, 0);

        start(13'h010, 2'd0);
        walk(13'h010, 2'd0, 0, 0, 0, '0, '0);
        start(13'h011, 2'd1);
        walk(13'h011, 2'd1, 0, 0, 0, '0, '0);
        start(13'h012, 2'd2);
        walk(13'h012, 2'd2, 0, 0, 0, '0, '0);
        idle_chk();
        chk("frags_three", stat_frags, 128);
        chk("tiles_three", stat_tiles, 3);

        start(13'h020, 2'd3);
        walk(13'h020, 2'd3, 0, 1, 0, '0, '0);
        idle_chk();

        start(13'h030, 2'd3);
        walk(13'h030, 2'd3, 0, 0, 1, 13'h031, 2'd0);
        walk(13'h031, 2'd0, 0, 0, 0, '0, '0);
        idle_chk();

        for (int t = 0; t < 4; t++) begin
            ra = 13'($urandom);
            rs = 2'($urandom);
            start(ra, rs);
            walk(ra, rs, 1, 0, 0, '0, '0);
            idle_chk();
        end

        start(13'h040, 2'd3);
        tile_in_valid  = 1'b0;
        frag_out_ready = 1'b1;
        cyc = 0;
        while (!(frag_out_valid && frag_out_x == 3'd2 && frag_out_y == 3'd4) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_2_4", cyc < 100, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", frag_out_valid, 0);
        chk("midrst_ready", tile_in_ready, 1);
        chk("midrst_last", frag_out_last, 0);
        chk("midrst_frags", stat_frags, 0);
        chk("midrst_tiles", stat_tiles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frag_out_ready = 1'b0;
        @(negedge clk);
        start(13'h041, 2'd3);
        walk(13'h041, 2'd3, 0, 0, 0, '0, '0);
        idle_chk();

        s_tv = 1'b1;
        s_sr = 2'd0;
        s_fr = 1'b1;
        @(negedge clk);
        s_tv = 1'b0;
        repeat (20) @(negedge clk);
        chk("sat_frags", s_frags, 15);
        chk("sat_still_walking", s_fv, 1);
        s_clr = 1'b1;
        @(negedge clk);
        s_clr = 1'b0;
        chk("clr_over_inc", s_frags, 0);
        @(negedge clk);
        chk("count_after_clr", s_frags, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
